im_load_arbiter: RTL and testbench
==================================

// Module: im_load_arbiter
// PURPOSE
//   Shares the single-port instruction memory between CPU fetch and a board-side loader (UART/debug) that writes a program image.
//   In RUN, fetch address passes straight to IM and read data returns to the CPU.
//   In LOAD, the CPU is stalled and fed NOPs while loader words are written to consecutive IM addresses.
//   On completion, the CPU PC is cleared so the new program runs from the load base.
// PARAMETERS
//   ADDR_W    10        IM word-address width (depth 2**ADDR_W)
//   DATA_W    32        instruction word width
//   NOP_WORD  32'h0     word returned to the CPU while stalled (sll $0,$0,0)
// PORTS
//   clk        in   1       system clock; all state on rising edge
//   rst        in   1       synchronous, active-high reset
//   PCNow      in   ADDR_W  CPU fetch word address
//   Instr      out  DATA_W  instruction to CPU
//   CpuStall   out  1       1 = CPU must hold PC and not commit
//   PcClr      out  1       one-cycle pulse: CPU loads PC <= LdBase
//   LoadReq    in   1       start-load request (level sampled in RUN)
//   LdBase     in   ADDR_W  first IM address of image, latched at start
//   LdLen      in   ADDR_W+1 word count 1..2**ADDR_W, latched at start
//   LdValid    in   1       loader word available
//   LdWord     in   DATA_W  loader word
//   LdReady    out  1       block accepts a word this cycle
//   LdAbort    in   1       terminate load early
//   LdDone     out  1       one-cycle pulse: load finished or aborted
//   Busy       out  1       1 in LOAD or FINISH
//   MemAddr    out  ADDR_W  IM address
//   MemWe      out  1       IM write enable
//   MemWData   out  DATA_W  IM write data
//   MemRData   in   DATA_W  IM combinational read data
// BEHAVIOUR
//   Reset (rst=1 at edge): state=RUN, cnt=0, LdDone=0, PcClr=0; MemWe forced 0 while rst high, regardless of state.
//   Handshake: a word transfers in a cycle with LdValid & LdReady; LdReady is 1 only in LOAD and not when LdAbort=1.
//   States:
//   RUN: MemAddr=PCNow, Instr=MemRData (0-cycle latency), CpuStall=0, LdReady=0, MemWe=0.
//     LoadReq=1 & LdLen!=0 -> latch base/len, cnt<=0 -> LOAD.
//     LdLen=0 or LdLen>2**ADDR_W -> request ignored, stay in RUN.
//   LOAD: CpuStall=1, Instr=NOP_WORD, MemAddr=(base+cnt) mod 2**ADDR_W (address wraps past top), MemWData=LdWord.
//     MemWe=LdValid & LdReady (same cycle, no buffering); each transfer increments cnt.
//     Transfer with cnt==len-1 -> FINISH.
//     LdAbort=1 -> FINISH, no write that cycle; words already written are kept.
//     Abort wins over a simultaneous valid word.
//     LoadReq is ignored while in LOAD.
//   FINISH (1 cycle): CpuStall=1, Instr=NOP_WORD, MemWe=0, LdDone=1, PcClr=1 -> RUN.
//   LdDone and PcClr are registered, high exactly in FINISH.
//   Busy=1 in LOAD and FINISH.
//   rst mid-load -> RUN next edge, cnt cleared, no PcClr/LdDone pulse; partial image stays in IM.
//   cnt is ADDR_W+1 bits, so a full-depth load (len=2**ADDR_W) does not overflow before FINISH.
// CONFIGURATION
//   IM_LOAD_CHECKSUM_EN defined:
//     - adds output LdSum[DATA_W-1:0], the mod-2**DATA_W sum of all words written in the current load.
//     - LdSum clears on entering LOAD and on rst, updates on each transfer, and holds after FINISH until the next load.
//   IM_LOAD_CHECKSUM_EN undefined: LdSum port absent, no adder logic.
// TESTING
//   T1 Reset/passthrough: rst 1 cycle, PCNow=5, mem[5]=32'h2008000A
//      -> Instr=32'h2008000A, CpuStall=0, MemWe=0, LdDone=0.
//   T2 Normal load: LdBase=0x10, LdLen=3, words A,B,C with LdValid gaps
//      -> writes to 0x10/0x11/0x12 only on handshake cycles; then 1-cycle LdDone=PcClr=1;
//      RUN resumes; LdSum=A+B+C if EN.
//   T3 Wrap: LdBase=0x3FE, LdLen=4 -> writes 0x3FE, 0x3FF, 0x000, 0x001; LdDone after 4th transfer.
//   T4 Abort: LdLen=8, assert LdAbort with LdValid=1 after 2 transfers
//      -> 3rd word not written, FINISH next cycle, mem keeps the first 2 words.
//   T5 Reset mid-load: rst during LOAD after 1 transfer
//      -> MemWe=0 that cycle, state RUN, no LdDone/PcClr, CpuStall=0 next cycle.
//   T6 Illegal request: LoadReq with LdLen=0 -> stays in RUN, Busy=0, no writes.
//      Full-depth load LdLen=1024 -> exactly 1024 writes, then FINISH.

Source files
------------

// File: rtl/im_load_arbiter.sv
// Instruction-memory port arbiter: CPU fetch in RUN, board-side loader writes in LOAD.
// Optional macro IM_LOAD_CHECKSUM_EN adds the LdSum running checksum output.
module im_load_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PCNow,
  output logic [DATA_W-1:0] Instr,
  output logic              CpuStall,
  output logic              PcClr,
  input  logic              LoadReq,
  input  logic [ADDR_W-1:0] LdBase,
  input  logic [ADDR_W:0]   LdLen,
  input  logic              LdValid,
  input  logic [DATA_W-1:0] LdWord,
  output logic              LdReady,
  input  logic              LdAbort,
  output logic              LdDone,
  output logic              Busy,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWe,
  output logic [DATA_W-1:0] MemWData,
`ifdef IM_LOAD_CHECKSUM_EN
  output logic [DATA_W-1:0] LdSum,
`endif
  input  logic [DATA_W-1:0] MemRData
);

  typedef enum logic [1:0] {RUN, LOAD, FINISH} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              xfer;
  logic              legal_req;

  assign legal_req = LoadReq && (LdLen != '0) && (LdLen <= DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    base_d   = base_q;
    MemAddr  = PCNow;
    Instr    = MemRData;
    CpuStall = 1'b0;
    LdReady  = 1'b0;
    xfer     = 1'b0;
    case (state_q)
      RUN: begin
        if (legal_req) begin
          base_d  = LdBase;
          len_d   = LdLen;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        CpuStall = 1'b1;
        Instr    = NOP_WORD;
        // Address wraps naturally at the top of the memory.
        MemAddr  = base_q + cnt_q[ADDR_W-1:0];
        LdReady  = !LdAbort;
        xfer     = LdValid && !LdAbort;
        if (LdAbort) begin
          state_d = FINISH;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) state_d = FINISH;
        end
      end
      FINISH: begin
        CpuStall = 1'b1;
        Instr    = NOP_WORD;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign MemWData = LdWord;
  assign MemWe    = xfer && !rst;
  assign LdDone   = (state_q == FINISH);
  assign PcClr    = (state_q == FINISH);
  assign Busy     = (state_q != RUN);

`ifdef IM_LOAD_CHECKSUM_EN
  // Cleared at the start of each load; holds after FINISH for the loader to read.
  always_ff @(posedge clk) begin
    if (rst) begin
      LdSum <= '0;
    end else if (state_q == RUN && state_d == LOAD) begin
      LdSum <= '0;
    end else if (xfer) begin
      LdSum <= LdSum + LdWord;
    end
  end
`endif

endmodule

// File: tb/tb_im_load_arbiter.sv
// Self-checking bench for im_load_arbiter: a scoreboard of expected IM writes plus per-scenario checks.
// Define IM_LOAD_CHECKSUM_EN to also check LdSum.
module tb_im_load_arbiter;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic [9:0]  PCNow;
  logic [31:0] Instr;
  logic        CpuStall;
  logic        PcClr;
  logic        LoadReq;
  logic [9:0]  LdBase;
  logic [10:0] LdLen;
  logic        LdValid;
  logic [31:0] LdWord;
  logic        LdReady;
  logic        LdAbort;
  logic        LdDone;
  logic        Busy;
  logic [9:0]  MemAddr;
  logic        MemWe;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
`ifdef IM_LOAD_CHECKSUM_EN
  logic [31:0] LdSum;
`endif

  logic [31:0] mem [0:1023];
  wr_t         q[$];
  logic [31:0] exp_sum;
  int          total;
  int          bad;

  im_load_arbiter dut (
    .clk(clk), .rst(rst), .PCNow(PCNow), .Instr(Instr), .CpuStall(CpuStall),
    .PcClr(PcClr), .LoadReq(LoadReq), .LdBase(LdBase), .LdLen(LdLen),
    .LdValid(LdValid), .LdWord(LdWord), .LdReady(LdReady), .LdAbort(LdAbort),
    .LdDone(LdDone), .Busy(Busy), .MemAddr(MemAddr), .MemWe(MemWe),
    .MemWData(MemWData),
`ifdef IM_LOAD_CHECKSUM_EN
    .LdSum(LdSum),
`endif
    .MemRData(MemRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign MemRData = mem[MemAddr];

  always @(posedge clk) begin
    if (MemWe === 1'b1) mem[MemAddr] <= MemWData;
  end

  // Every write the DUT issues must match the oldest expected write.
  always @(negedge clk) begin
    if (MemWe === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_write addr=%h data=%h expected none", MemAddr, MemWData);
      end else begin
        wr_t e;
        e = q.pop_front();
        if (MemAddr !== e.addr || MemWData !== e.data) begin
          bad++;
          $display("[TB] FAIL write got addr=%h data=%h expected addr=%h data=%h",
                   MemAddr, MemWData, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [9:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    q.push_back(e);
    exp_sum = exp_sum + data;
    LdValid = 1'b1;
    LdWord  = data;
    tick();
    LdValid = 1'b0;
  endtask

  task automatic start_load(input logic [9:0] base, input logic [10:0] len);
    LdBase  = base;
    LdLen   = len;
    LoadReq = 1'b1;
    exp_sum = '0;
    tick();
    LoadReq = 1'b0;
  endtask

  task automatic check_finish(input string name);
    @(negedge clk);
    total++;
    if (LdDone !== 1'b1 || PcClr !== 1'b1 || CpuStall !== 1'b1 || MemWe !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_finish got done=%b pcclr=%b stall=%b we=%b expected 1 1 1 0",
               name, LdDone, PcClr, CpuStall, MemWe);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_pending got %0d writes outstanding expected 0", name, q.size());
    end
    tick();
    @(negedge clk);
    total++;
    if (LdDone !== 1'b0 || PcClr !== 1'b0 || Busy !== 1'b0 || CpuStall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_resume got done=%b pcclr=%b busy=%b stall=%b expected 0 0 0 0",
               name, LdDone, PcClr, Busy, CpuStall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if (MemWe !== 1'b0 || Busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_hold got we=%b busy=%b expected 0 0", MemWe, Busy);
    end
    tick();
    rst   = 1'b0;
    PCNow = 10'd5;
    @(negedge clk);
    total++;
    if (Instr !== 32'h2008000A || CpuStall !== 1'b0 || MemWe !== 1'b0 || LdDone !== 1'b0
        || PcClr !== 1'b0 || MemAddr !== 10'd5) begin
      bad++;
      $display("[TB] FAIL passthrough got instr=%h stall=%b we=%b done=%b pcclr=%b addr=%h expected 2008000a 0 0 0 0 005",
               Instr, CpuStall, MemWe, LdDone, PcClr, MemAddr);
    end
    tick();
  endtask

  task automatic test_normal_load();
    logic [31:0] words [3];
    words[0] = 32'h1111_000A;
    words[1] = 32'h2222_000B;
    words[2] = 32'h3333_000C;
    start_load(10'h010, 11'd3);
    @(negedge clk);
    total++;
    if (CpuStall !== 1'b1 || Busy !== 1'b1 || Instr !== 32'h0 || LdReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL load_entry got stall=%b busy=%b instr=%h ready=%b expected 1 1 0 1",
               CpuStall, Busy, Instr, LdReady);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      send_word(10'h010 + 10'(i), words[i]);
    end
    check_finish("normal");
`ifdef IM_LOAD_CHECKSUM_EN
    total++;
    if (LdSum !== exp_sum) begin
      bad++;
      $display("[TB] FAIL checksum got %h expected %h", LdSum, exp_sum);
    end
`endif
    total++;
    if (mem[10'h011] !== words[1]) begin
      bad++;
      $display("[TB] FAIL normal_mem got %h expected %h", mem[10'h011], words[1]);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [9:0] addrs [4];
    addrs[0] = 10'h3FE;
    addrs[1] = 10'h3FF;
    addrs[2] = 10'h000;
    addrs[3] = 10'h001;
    start_load(10'h3FE, 11'd4);
    for (int i = 0; i < 4; i++) send_word(addrs[i], 32'hCAFE_0000 + 32'(i));
    check_finish("wrap");
    tick();
  endtask

  task automatic test_abort();
    mem[10'h082] = 32'hDEAD_BEEF;
    start_load(10'h080, 11'd8);
    send_word(10'h080, 32'hAB00_0001);
    send_word(10'h081, 32'hAB00_0002);
    LdValid = 1'b1;
    LdAbort = 1'b1;
    LdWord  = 32'hAB00_0003;
    @(negedge clk);
    total++;
    if (LdReady !== 1'b0 || MemWe !== 1'b0 || LdDone !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_cycle got ready=%b we=%b done=%b expected 0 0 0", LdReady, MemWe, LdDone);
    end
    tick();
    LdValid = 1'b0;
    LdAbort = 1'b0;
    check_finish("abort");
    total++;
    if (mem[10'h082] !== 32'hDEAD_BEEF || mem[10'h080] !== 32'hAB00_0001) begin
      bad++;
      $display("[TB] FAIL abort_mem got m82=%h m80=%h expected deadbeef ab000001", mem[10'h082], mem[10'h080]);
    end
    tick();
  endtask

  task automatic test_reset_midload();
    mem[10'h041] = 32'h0;
    start_load(10'h040, 11'd4);
    send_word(10'h040, 32'h5555_0001);
    LdValid = 1'b1;
    LdWord  = 32'h5555_0002;
    rst     = 1'b1;
    @(negedge clk);
    total++;
    if (MemWe !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_we got %b expected 0", MemWe);
    end
    tick();
    rst     = 1'b0;
    LdValid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (Busy !== 1'b0 || CpuStall !== 1'b0 || LdDone !== 1'b0 || PcClr !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rst_mid got busy=%b stall=%b done=%b pcclr=%b expected 0 0 0 0",
                 Busy, CpuStall, LdDone, PcClr);
      end
      tick();
    end
    total++;
    if (mem[10'h040] !== 32'h5555_0001 || mem[10'h041] !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rst_mem got m40=%h m41=%h expected 55550001 00000000", mem[10'h040], mem[10'h041]);
    end
  endtask

  task automatic test_illegal_and_full();
    logic [10:0] lens [2];
    lens[0] = 11'd0;
    lens[1] = 11'd1025;
    for (int i = 0; i < 2; i++) begin
      start_load(10'h020, lens[i]);
      LdValid = 1'b1;
      LdWord  = 32'hBAD0_0000;
      @(negedge clk);
      total++;
      if (Busy !== 1'b0 || CpuStall !== 1'b0 || MemWe !== 1'b0) begin
        bad++;
        $display("[TB] FAIL illegal_len%0d got busy=%b stall=%b we=%b expected 0 0 0",
                 lens[i], Busy, CpuStall, MemWe);
      end
      tick();
      LdValid = 1'b0;
    end
    start_load(10'h000, 11'd1024);
    for (int i = 0; i < 1024; i++) begin
      if (i == 1023) begin
        @(negedge clk);
        total++;
        if (Busy !== 1'b1 || LdDone !== 1'b0) begin
          bad++;
          $display("[TB] FAIL full_last got busy=%b done=%b expected 1 0", Busy, LdDone);
        end
      end
      send_word(10'(i), 32'hF000_0000 ^ 32'(i));
    end
    check_finish("full");
    tick();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    exp_sum = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[5]  = 32'h2008000A;
    rst     = 1'b1;
    PCNow   = '0;
    LoadReq = 1'b0;
    LdBase  = '0;
    LdLen   = '0;
    LdValid = 1'b0;
    LdWord  = '0;
    LdAbort = 1'b0;
    test_reset();
    test_normal_load();
    test_wrap();
    test_abort();
    test_reset_midload();
    test_illegal_and_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
